// File: rtl/fifo_bus_param.sv
// Parametrised single-clock FIFO with nearly-full flag and saturating overflow/underflow
// counters, exposed on a 4-address slice of the ibus/obus register file.
module fifo_bus_param #(
    parameter int          W         = 33,
    parameter int          DEPTH     = 2048,
    parameter logic [15:0] BASEADDR  = 16'h0,
    parameter int          THRESH_PU = DEPTH - 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [33:0]  ibus,
    output logic [15:0]  obus,
    input  logic [W-1:0] d,
    input  logic         wen,
    input  logic         ren,
    output logic [W-1:0] q,
    output logic         nempty,
    output logic         full,
    output logic         nearlyfull,
    output logic [15:0]  nwords
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = (PW < 16) ? PW : 16;

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, fill;
    logic [W-1:0]    q_q;
    logic [15:0]     ovf_q, ovf_d, unf_q, unf_d;
    logic [TW-1:0]   thresh_q, thresh_d;
    logic            nf_q, nf_d;
    logic            do_wr, do_rd;
    logic            bus_wr, bus_hit;
    logic [15:0]     bus_off, bus_rdata;
    logic            unused_bus;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The ibus clock bit is the same net as clk; upper write-data bits may exceed the threshold width.
    assign unused_bus = ^{ibus[33], ibus[15:0]};
    assign bus_wr     = ibus[32];
    assign bus_off    = ibus[31:16] - BASEADDR;
    assign bus_hit    = (bus_off[15:2] == 14'd0);

    always_comb begin
        fill       = wptr_q - rptr_q;
        full       = (fill == PW'(DEPTH));
        nempty     = (fill != '0);
        nwords     = 16'(fill);
        nearlyfull = nf_q;
        q          = q_q;
        do_wr      = wen && (!full || ren);
        do_rd      = ren && nempty;
    end

    always_comb begin
        wptr_d   = do_wr ? wptr_q + PW'(1) : wptr_q;
        rptr_d   = do_rd ? rptr_q + PW'(1) : rptr_q;
        nf_d     = (fill >= PW'(thresh_q));
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (wen && full && !ren)
            ovf_d = sat_inc(ovf_q);
        if (ren && !nempty)
            unf_d = sat_inc(unf_q);
        // A bus write clears a counter even if it would have incremented this cycle.
        if (bus_wr && bus_hit) begin
            case (bus_off[1:0])
                2'd1:    thresh_d = ibus[TW-1:0];
                2'd2:    ovf_d    = 16'd0;
                2'd3:    unf_d    = 16'd0;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_rdata = 16'd0;
        case (bus_off[1:0])
            2'd0:    bus_rdata = nwords;
            2'd1:    bus_rdata = 16'(thresh_q);
            2'd2:    bus_rdata = ovf_q;
            default: bus_rdata = unf_q;
        endcase
    end

    assign obus = bus_hit ? bus_rdata : 16'bz;

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wptr_q[AW-1:0]] <= d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            q_q      <= '0;
            ovf_q    <= 16'd0;
            unf_q    <= 16'd0;
            thresh_q <= TW'(THRESH_PU);
            nf_q     <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            thresh_q <= thresh_d;
            nf_q     <= nf_d;
            if (ren)
                q_q <= do_rd ? mem[rptr_q[AW-1:0]] : '0;
        end
    end

endmodule

// File: tb/tb_fifo_bus_param.sv
// Bench for fifo_bus_param: table-driven basic sequence plus scoreboard-checked corner cases.
module tb_fifo_bus_param;

    localparam int          W     = 12;
    localparam int          DEPTH = 16;
    localparam logic [15:0] BASE  = 16'h0040;
    localparam int          TPU   = 12;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          bwr   = 1'b0;
    logic [15:0]   baddr = 16'h0;
    logic [15:0]   bdata = 16'h0;
    wire  [33:0]   ibus  = {clk, bwr, baddr, bdata};
    wire  [15:0]   obus;
    logic [W-1:0]  d     = '0;
    logic          wen   = 1'b0;
    logic          ren   = 1'b0;
    logic [W-1:0]  q;
    logic          nempty, full, nearlyfull;
    logic [15:0]   nwords;

    fifo_bus_param #(.W(W), .DEPTH(DEPTH), .BASEADDR(BASE), .THRESH_PU(TPU)) dut (
        .clk(clk), .rst_n(rst_n), .ibus(ibus), .obus(obus), .d(d), .wen(wen), .ren(ren),
        .q(q), .nempty(nempty), .full(full), .nearlyfull(nearlyfull), .nwords(nwords)
    );

    always #5 clk = ~clk;

    int           n_chk = 0;
    int           n_fail = 0;
    logic [W-1:0] model[$];
    logic [W-1:0] sb[$];
    int           thr_m = TPU;
    int           ovf_m = 0;
    int           unf_m = 0;
    logic         nf_m  = 1'b0;

    typedef struct {
        logic         w;
        logic         r;
        logic [W-1:0] dv;
        int           exp_nw;
        logic         exp_ne;
        logic [W-1:0] exp_q;
    } vec_t;
    vec_t vt[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic w, input logic [W-1:0] dv, input logic r,
                         input logic bw = 1'b0, input logic [15:0] ba = 16'h0,
                         input logic [15:0] bd = 16'h0);
        int sz;
        wen = w; d = dv; ren = r; bwr = bw; baddr = ba; bdata = bd;
        sz = model.size();
        nf_m = (sz >= thr_m);
        if (r) sb.push_back(sz > 0 ? model[0] : '0);
        if (r && sz > 0) void'(model.pop_front());
        if (w && (sz < DEPTH || r)) model.push_back(dv);
        if (bw && ba == BASE + 16'd2) ovf_m = 0;
        else if (w && sz == DEPTH && !r && ovf_m < 65535) ovf_m++;
        if (bw && ba == BASE + 16'd3) unf_m = 0;
        else if (r && sz == 0 && unf_m < 65535) unf_m++;
        if (bw && ba == BASE + 16'd1) thr_m = int'(bd[4:0]);
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; bwr = 1'b0;
        if (r) chk("q", q, sb.pop_front());
        chk("nwords", nwords, model.size());
        chk("nempty", nempty, model.size() > 0);
        chk("full", full, model.size() == DEPTH);
        chk("nearlyfull", nearlyfull, nf_m);
    endtask

    task automatic rd_reg(input logic [15:0] off, input logic [15:0] exp, input string nm);
        @(negedge clk);
        bwr = 1'b0; baddr = BASE + off;
        #1;
        chk(nm, obus, exp);
    endtask

    task automatic chk_z(input logic [15:0] addr, input string nm);
        @(negedge clk);
        bwr = 1'b0; baddr = addr;
        #1;
        n_chk++;
        if (!($isunknown(obus) || obus == 16'h0)) begin
            n_fail++;
            $display("FAIL %s: got %0h expected z", nm, obus);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model.delete(); sb.delete();
        thr_m = TPU; ovf_m = 0; unf_m = 0; nf_m = 1'b0;
        chk("rst_nwords", nwords, 0);
        chk("rst_nempty", nempty, 0);
        chk("rst_full", full, 0);
        chk("rst_q", q, 0);
        chk("rst_nearlyfull", nearlyfull, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_n;
        int guard;
        vt[0]  = '{1'b1, 1'b0, 12'd1, 1, 1'b1, 12'd0};
        vt[1]  = '{1'b1, 1'b0, 12'd2, 2, 1'b1, 12'd0};
        vt[2]  = '{1'b1, 1'b0, 12'd3, 3, 1'b1, 12'd0};
        vt[3]  = '{1'b1, 1'b0, 12'd4, 4, 1'b1, 12'd0};
        vt[4]  = '{1'b1, 1'b0, 12'd5, 5, 1'b1, 12'd0};
        vt[5]  = '{1'b0, 1'b1, 12'd0, 4, 1'b1, 12'd1};
        vt[6]  = '{1'b0, 1'b1, 12'd0, 3, 1'b1, 12'd2};
        vt[7]  = '{1'b0, 1'b1, 12'd0, 2, 1'b1, 12'd3};
        vt[8]  = '{1'b0, 1'b1, 12'd0, 1, 1'b1, 12'd4};
        vt[9]  = '{1'b0, 1'b1, 12'd0, 0, 1'b0, 12'd5};
        vt[10] = '{1'b0, 1'b1, 12'd0, 0, 1'b0, 12'd0};

        do_reset();
        rd_reg(16'd1, 16'(TPU), "thresh_pu");

        // Basic write/read, then underflow
        for (int i = 0; i < 11; i++) begin
            cycle(vt[i].w, vt[i].dv, vt[i].r);
            chk("vec_nwords", nwords, vt[i].exp_nw);
            chk("vec_nempty", nempty, vt[i].exp_ne);
            if (vt[i].r) chk("vec_q", q, vt[i].exp_q);
        end
        rd_reg(16'd3, 16'd1, "unf_count");

        // Full, dropped write, wen+ren while full
        cycle(1'b0, '0, 1'b0, 1'b1, BASE + 16'd3, 16'h1234);
        rd_reg(16'd3, 16'd0, "unf_clear");
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, W'(12'h200 + i), 1'b0);
        chk("full_flag", full, 1);
        chk("full_nwords", nwords, 16);
        cycle(1'b1, 12'hEEE, 1'b0);
        rd_reg(16'd2, 16'd1, "ovf_count");
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, W'(12'h300 + i), 1'b1);
            chk("full_rw_nwords", nwords, 16);
        end
        cycle(1'b0, '0, 1'b0, 1'b1, BASE, 16'h0005);
        rd_reg(16'd0, 16'd16, "nwords_ro");
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
        chk("drain_last_q", q, 12'h303);

        // Nearly-full threshold (only low 5 bits stored)
        cycle(1'b0, '0, 1'b0, 1'b1, BASE + 16'd1, 16'hFFEA);
        rd_reg(16'd1, 16'd10, "thresh_rd");
        for (int i = 0; i < 9; i++) cycle(1'b1, W'(12'h500 + i), 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("nf_at9", nearlyfull, 0);
        cycle(1'b1, 12'h509, 1'b0);
        chk("nf_lag", nearlyfull, 0);
        cycle(1'b0, '0, 1'b0);
        chk("nf_set", nearlyfull, 1);
        cycle(1'b0, '0, 1'b1);
        chk("nf_read_lag", nearlyfull, 1);
        cycle(1'b0, '0, 1'b0);
        chk("nf_clear", nearlyfull, 0);
        while (model.size() > 0) cycle(1'b0, '0, 1'b1);

        // Continuous streaming across pointer wrap
        cycle(1'b0, '0, 1'b0, 1'b1, BASE + 16'd2, 16'h0);
        rd_reg(16'd2, 16'd0, "ovf_clear");
        wr_n = 0;
        guard = 0;
        while ((wr_n < 3 * DEPTH || model.size() > 0) && guard < 200) begin
            logic w, r;
            w = (wr_n < 3 * DEPTH);
            r = (wr_n >= 2 && model.size() > 0);
            cycle(w, W'(12'h400 + wr_n), r);
            if (w) wr_n++;
            guard++;
        end
        chk("stream_done", guard < 200, 1);
        chk("stream_last_q", q, 12'h42F);
        rd_reg(16'd2, 16'd0, "stream_ovf");
        rd_reg(16'd3, 16'd0, "stream_unf");

        // Clear beats same-cycle increment; reset mid-operation
        cycle(1'b0, '0, 1'b1, 1'b1, BASE + 16'd3, 16'h0);
        rd_reg(16'd3, 16'd0, "clear_wins");
        cycle(1'b0, '0, 1'b1);
        rd_reg(16'd3, 16'd1, "unf_again");
        for (int i = 0; i < 7; i++) cycle(1'b1, W'(12'h600 + i), 1'b0);
        rd_reg(16'd0, 16'd7, "fill7");
        chk_z(BASE + 16'd4, "obus_hi_z");
        chk_z(BASE - 16'd1, "obus_lo_z");
        do_reset();
        rd_reg(16'd0, 16'd0, "rst_fill");
        rd_reg(16'd1, 16'(TPU), "rst_thresh");
        rd_reg(16'd2, 16'd0, "rst_ovf");
        rd_reg(16'd3, 16'd0, "rst_unf");
        chk_z(BASE + 16'd4, "rst_obus_z");
        cycle(1'b1, 12'h777, 1'b0);
        cycle(1'b0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
